// File: rtl/simple_cpu_top.sv
// Simple CPU FPGA top: single-cycle MIPS-subset core plus a two-bank, 4-digit hex display of testv.
// The instruction ROM image is supplied as the packed parameter IMEM_INIT, with word 0 in the low 32 bits.

module simple_cpu_core #(
    parameter int                         IMEM_WORDS = 256,
    parameter int                         DMEM_WORDS = 256,
    parameter logic [IMEM_WORDS*32-1:0]   IMEM_INIT  = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);
    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_WORDS);

    logic [31:0]   pc_q;
    logic [31:0]   NPC;
    logic [31:0]   instruction;
    logic [31:0]   regs_q [32];
    logic [31:0]   dmem_q [DMEM_WORDS];
    logic [IW+4:0] rom_base;
    logic [5:0]    opcode, funct;
    logic [4:0]    rs, rt, rd, shamt;
    logic [31:0]   rs_val, rt_val, imm_s, imm_z, pc_plus4, mem_addr;
    logic [DW-1:0] dmem_idx;
    logic          mem_we;
    logic          unused_addr_bits;

    // The ROM index is the low PC word bits, so fetches past the last word wrap around.
    assign rom_base    = {pc_q[IW+1:2], 5'd0};
    assign instruction = IMEM_INIT[rom_base +: 32];

    assign opcode   = instruction[31:26];
    assign rs       = instruction[25:21];
    assign rt       = instruction[20:16];
    assign rd       = instruction[15:11];
    assign shamt    = instruction[10:6];
    assign funct    = instruction[5:0];
    assign imm_s    = {{16{instruction[15]}}, instruction[15:0]};
    assign imm_z    = {16'd0, instruction[15:0]};
    assign rs_val   = regs_q[rs];
    assign rt_val   = regs_q[rt];
    assign pc_plus4 = pc_q + 32'd4;
    assign mem_addr = rs_val + imm_s;
    assign dmem_idx = mem_addr[DW+1:2];
    assign unused_addr_bits = ^{mem_addr[31:DW+2], mem_addr[1:0]};

    always_comb begin
        NPC      = pc_plus4;
        rf_we    = 1'b0;
        rf_waddr = rt;
        rf_wdata = '0;
        mem_we   = 1'b0;
        case (opcode)
            6'h00: begin
                rf_we    = 1'b1;
                rf_waddr = rd;
                case (funct)
                    6'h21:   rf_wdata = rs_val + rt_val;
                    6'h23:   rf_wdata = rs_val - rt_val;
                    6'h24:   rf_wdata = rs_val & rt_val;
                    6'h25:   rf_wdata = rs_val | rt_val;
                    6'h2A:   rf_wdata = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    6'h00:   rf_wdata = rt_val << shamt;
                    6'h02:   rf_wdata = rt_val >> shamt;
                    default: rf_we    = 1'b0;
                endcase
            end
            6'h09: begin rf_we = 1'b1; rf_wdata = rs_val + imm_s; end
            6'h0C: begin rf_we = 1'b1; rf_wdata = rs_val & imm_z; end
            6'h0D: begin rf_we = 1'b1; rf_wdata = rs_val | imm_z; end
            6'h0F: begin rf_we = 1'b1; rf_wdata = {instruction[15:0], 16'd0}; end
            6'h23: begin rf_we = 1'b1; rf_wdata = dmem_q[dmem_idx]; end
            6'h2B: mem_we = 1'b1;
            6'h04: if (rs_val == rt_val) NPC = pc_plus4 + {imm_s[29:0], 2'b00};
            6'h02: NPC = {pc_plus4[31:28], instruction[25:0], 2'b00};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            pc_q <= NPC;
            if (rf_we && rf_waddr != 5'd0) regs_q[rf_waddr] <= rf_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) dmem_q[dmem_idx] <= rt_val;
    end
endmodule

module simple_cpu_top #(
    parameter int                         IMEM_WORDS = 256,
    parameter int                         DMEM_WORDS = 256,
    parameter int                         SCAN_BITS  = 16,
    parameter logic [IMEM_WORDS*32-1:0]   IMEM_INIT  = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [6:0] seg7_0_7bit,
    output logic [6:0] seg7_1_7bit,
    output logic [3:0] seg7_0_an,
    output logic [3:0] seg7_1_an,
    output logic       seg7_0_dp,
    output logic       seg7_1_dp
);
    logic                 rf_we;
    logic [4:0]           rf_waddr;
    logic [31:0]          rf_wdata;
    logic [31:0]          testv_q, testv_d, testv;
    logic [SCAN_BITS-1:0] cnt_q, cnt_d;
    logic [1:0]           digit_sel;
    logic [3:0]           nib_0, nib_1;

    simple_cpu_core #(
        .IMEM_WORDS (IMEM_WORDS),
        .DMEM_WORDS (DMEM_WORDS),
        .IMEM_INIT  (IMEM_INIT)
    ) mips1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata)
    );

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_seg = 7'h3F;  4'h1: hex_seg = 7'h06;
            4'h2: hex_seg = 7'h5B;  4'h3: hex_seg = 7'h4F;
            4'h4: hex_seg = 7'h66;  4'h5: hex_seg = 7'h6D;
            4'h6: hex_seg = 7'h7D;  4'h7: hex_seg = 7'h07;
            4'h8: hex_seg = 7'h7F;  4'h9: hex_seg = 7'h6F;
            4'hA: hex_seg = 7'h77;  4'hB: hex_seg = 7'h7C;
            4'hC: hex_seg = 7'h39;  4'hD: hex_seg = 7'h5E;
            4'hE: hex_seg = 7'h79;  default: hex_seg = 7'h71;
        endcase
    endfunction

    // testv shadows $2, so it tracks every write the core commits to that register.
    always_comb begin
        testv_d = testv_q;
        if (rf_we && rf_waddr == 5'd2) testv_d = rf_wdata;
        cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            testv_q <= '0;
            cnt_q   <= '0;
        end else begin
            testv_q <= testv_d;
            cnt_q   <= cnt_d;
        end
    end

    assign testv       = testv_q;
    assign digit_sel   = cnt_q[SCAN_BITS-1 -: 2];
    assign nib_0       = testv_q[{1'b0, digit_sel, 2'b00} +: 4];
    assign nib_1       = testv_q[{1'b1, digit_sel, 2'b00} +: 4];
    assign seg7_0_an   = 4'b0001 << digit_sel;
    assign seg7_1_an   = 4'b0001 << digit_sel;
    assign seg7_0_7bit = hex_seg(nib_0);
    assign seg7_1_7bit = hex_seg(nib_1);
    assign seg7_0_dp   = 1'b0;
    assign seg7_1_dp   = 1'b0;
endmodule

// File: tb/tb_simple_cpu_top.sv
// Directed bench for simple_cpu_top: runs a fixed program and checks testv, NPC, fetch and display scan.
// Expected values below are hand-derived from the program listing.

module tb_simple_cpu_top;
    localparam int N_W = 29;
    localparam int N_EXEC = 25;

    localparam logic [N_W*32-1:0] PROG_W = {
        32'h1000FFFF,  // 0x70 beq $0,$0,-1
        32'h34421234,  // 0x6C ori  $2,$2,0x1234
        32'h3C02ABCD,  // 0x68 lui  $2,0xABCD
        32'hFC000000,  // 0x64 undefined -> nop
        32'h10400005,  // 0x60 beq  $2,$0,+5 (not taken)
        32'h3402DEAD,  // 0x5C skipped
        32'h10430001,  // 0x58 beq  $2,$3,+1 (taken)
        32'h00831024,  // 0x54 and  $2,$4,$3
        32'h3082F0F0,  // 0x50 andi $2,$4,0xF0F0
        32'h00041702,  // 0x4C srl  $2,$4,28
        32'h00051100,  // 0x48 sll  $2,$5,4
        32'h0045102A,  // 0x44 slt  $2,$2,$5
        32'h00051023,  // 0x40 subu $2,$0,$5
        32'h3402DEAD,  // 0x3C skipped
        32'h3402DEAD,  // 0x38 skipped
        32'h08000010,  // 0x34 j    0x40
        32'h00851021,  // 0x30 addu $2,$4,$5
        32'h24050001,  // 0x2C addiu $5,$0,1
        32'h3484FFFF,  // 0x28 ori  $4,$4,0xFFFF
        32'h3C047FFF,  // 0x24 lui  $4,0x7FFF
        32'h00001025,  // 0x20 or   $2,$0,$0
        32'h24000007,  // 0x1C addiu $0,$0,7
        32'h00421021,  // 0x18 addu $2,$2,$2
        32'h8C02000B,  // 0x14 lw   $2,11($0)
        32'hAC030008,  // 0x10 sw   $3,8($0)
        32'h24030005,  // 0x0C addiu $3,$0,5
        32'h3442EF01,  // 0x08 ori  $2,$2,0xEF01
        32'h3C02ABCD,  // 0x04 lui  $2,0xABCD
        32'h34021234   // 0x00 ori  $2,$0,0x1234
    };
    localparam logic [8191:0] IMG = {{((256 - N_W) * 32){1'b0}}, PROG_W};

    localparam logic [31:0] EXEC_PC [N_EXEC+1] = '{
        32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20,
        32'h24, 32'h28, 32'h2C, 32'h30, 32'h34, 32'h40, 32'h44, 32'h48, 32'h4C,
        32'h50, 32'h54, 32'h58, 32'h60, 32'h64, 32'h68, 32'h6C, 32'h70};
    localparam logic [31:0] EXP_TV [N_EXEC] = '{
        32'h00001234, 32'hABCD0000, 32'hABCDEF01, 32'hABCDEF01, 32'hABCDEF01,
        32'h00000005, 32'h0000000A, 32'h0000000A, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF,
        32'h00000001, 32'h00000010, 32'h00000007, 32'h0000F0F0, 32'h00000005,
        32'h00000005, 32'h00000005, 32'h00000005, 32'hABCD0000, 32'hABCD1234};
    localparam logic [6:0] FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic       clk, rst_n;
    logic [6:0] seg7_0_7bit, seg7_1_7bit;
    logic [3:0] seg7_0_an, seg7_1_an;
    logic       seg7_0_dp, seg7_1_dp;

    int n_cmp = 0;
    int n_mis = 0;
    int ncyc  = 0;

    simple_cpu_top #(
        .IMEM_WORDS (256),
        .DMEM_WORDS (256),
        .SCAN_BITS  (4),
        .IMEM_INIT  (IMG)
    ) top (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg7_0_7bit (seg7_0_7bit),
        .seg7_1_7bit (seg7_1_7bit),
        .seg7_0_an   (seg7_0_an),
        .seg7_1_an   (seg7_1_an),
        .seg7_0_dp   (seg7_0_dp),
        .seg7_1_dp   (seg7_1_dp)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        logic [31:0] idx;
        idx = pc >> 2;
        return PROG_W[idx*32 +: 32];
    endfunction

    initial begin
        logic [1:0]  sel;
        logic [31:0] tv;
        logic [3:0]  n0, n1;

        rst_n = 1'b0;
        #5 rst_n = 1'b1;
        #1;
        chk("rst_npc",   top.mips1.NPC, 32'h4);
        chk("rst_instr", top.mips1.instruction, 32'h34021234);
        chk("rst_testv", top.testv, 32'h0);
        chk("rst_an0",   {28'd0, seg7_0_an}, 32'h1);
        chk("rst_an1",   {28'd0, seg7_1_an}, 32'h1);
        chk("rst_seg0",  {25'd0, seg7_0_7bit}, 32'h3F);
        chk("rst_seg1",  {25'd0, seg7_1_7bit}, 32'h3F);

        for (int k = 0; k < N_EXEC; k++) begin
            chk($sformatf("instr_%0d", k), top.mips1.instruction, rom_word(EXEC_PC[k]));
            chk($sformatf("npc_%0d", k), top.mips1.NPC, EXEC_PC[k+1]);
            step();
            chk($sformatf("testv_%0d", k), top.testv, EXP_TV[k]);
            if (k == 0) begin
                chk("first_an0",  {28'd0, seg7_0_an}, 32'h1);
                chk("first_seg0", {25'd0, seg7_0_7bit}, 32'h66);
            end
        end

        // Parked in the beq self-loop with testv = ABCD1234: walk all four scan positions.
        tv = 32'hABCD1234;
        for (int c = 0; c < 16; c++) begin
            step();
            sel = 2'((ncyc >> 2) & 3);
            n0  = 4'((tv >> (4 * sel)) & 32'hF);
            n1  = 4'((tv >> (16 + 4 * sel)) & 32'hF);
            chk("loop_npc",   top.mips1.NPC, 32'h70);
            chk("loop_instr", top.mips1.instruction, 32'h1000FFFF);
            chk("loop_testv", top.testv, tv);
            chk("loop_an0",   {28'd0, seg7_0_an}, 32'h1 << sel);
            chk("loop_an1",   {28'd0, seg7_1_an}, 32'h1 << sel);
            chk("loop_seg0",  {25'd0, seg7_0_7bit}, {25'd0, FONT[n0]});
            chk("loop_seg1",  {25'd0, seg7_1_7bit}, {25'd0, FONT[n1]});
            chk("loop_dp",    {30'd0, seg7_0_dp, seg7_1_dp}, 32'h0);
        end

        #4 rst_n = 1'b0;
        ncyc = 0;
        #1;
        chk("midrst_testv", top.testv, 32'h0);
        chk("midrst_npc",   top.mips1.NPC, 32'h4);
        chk("midrst_an0",   {28'd0, seg7_0_an}, 32'h1);
        chk("midrst_seg1",  {25'd0, seg7_1_7bit}, 32'h3F);
        #9 rst_n = 1'b1;
        step();
        chk("restart_testv0", top.testv, 32'h00001234);
        chk("restart_npc0",   top.mips1.NPC, 32'h8);
        step();
        chk("restart_testv1", top.testv, 32'hABCD0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
